sysid_check_master: RTL and testbench
=====================================

Name: sysid_check_master

Overview:
- Avalon-MM read master that interrogates a system-ID slave after reset or on software/debug request.
- Reads the ID word at word address 0, then the timestamp word at word address 1.
- Compares both words against expected build constants and reports pass/fail/timeout.
- Sits beside the Nios II subsystem, so board bring-up logic can refuse a mismatched FPGA image before the CPU is released.

Parameters:
- ADDR_W, 1, width of word address driven to the slave.
- DATA_W, 32, read data width.
- EXPECTED_ID, 32'h0000_0000, value required at address 0.
- EXPECTED_TS, 32'h58BE_BBBF, value required at address 1.
- USE_RDV, 0, 0 = fixed-latency-0 slave (data valid when read accepted); 1 = pipelined slave using readdatavalid.
- TIMEOUT_CYC, 255, max cycles per transaction (issue to data) before abort; 8-bit counter.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to run a check
- avm_address  out  ADDR_W  word address
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; tie 0 for slaves without it
- avm_readdata  in  DATA_W  read data
- avm_readdatavalid  in  1  used only when USE_RDV=1
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when check ends
- pass  out  1  id_ok & ts_ok & !timeout, held until next start
- id_ok  out  1  ID matched
- ts_ok  out  1  timestamp matched
- timeout  out  1  a transaction exceeded TIMEOUT_CYC
- id_value  out  DATA_W  captured ID word
- ts_value  out  DATA_W  captured timestamp word

Behaviour:
- Reset values, applied immediately on reset assertion:
  - avm_read=0, avm_address=0.
  - busy, done, pass, id_ok, ts_ok, timeout = 0.
  - id_value = ts_value = 0.
  - state=IDLE, timeout counter=0.
- Reset mid-operation drops avm_read at once. No outstanding-read tracking survives reset.
- States: IDLE, ID_CMD, ID_WAIT, TS_CMD, TS_WAIT, FIN.
- IDLE:
  - start=1 → ID_CMD.
  - Clear id_ok, ts_ok, timeout, pass; set busy; counter=0.
  - Result registers keep their old values until overwritten.
- ID_CMD:
  - avm_read=1, avm_address=0.
  - read and address are held stable while avm_waitrequest=1.
  - Acceptance is the cycle with read=1 and waitrequest=0.
  - USE_RDV=0: capture avm_readdata into id_value on acceptance, then → TS_CMD.
  - USE_RDV=1: on acceptance → ID_WAIT with read=0.
- ID_WAIT (USE_RDV=1 only): on readdatavalid, capture id_value → TS_CMD.
- TS_CMD / TS_WAIT: same as ID_CMD / ID_WAIT with address 1, capturing into ts_value, then → FIN.
- Compare:
  - id_ok = (captured ID == EXPECTED_ID), evaluated on the captured value.
  - ts_ok likewise against EXPECTED_TS.
  - Full DATA_W equality, no masking.
- Timeout:
  - The counter increments every cycle in *_CMD and *_WAIT and resets to 0 on each transition into a CMD state.
  - Reaching TIMEOUT_CYC → FIN with timeout=1. avm_read is deasserted that cycle even if waitrequest is still high; this is the only permitted violation of the hold rule.
  - A readdatavalid arriving after abort is ignored.
- FIN: done=1 for exactly one cycle, busy=0, pass updated → IDLE.
- Latency with USE_RDV=0 and waitrequest=0: start at cycle N, reads at N+1 and N+2, done at N+3.
- start while busy is ignored. A start in the same cycle as done is ignored; the next start is accepted from IDLE.
- readdatavalid outside a WAIT state is ignored.

Decomposition:
- Shared package sysid_pkg holds:
  - state enum (6 states)
  - ADDR_ID=0, ADDR_TS=1 constants
  - default EXPECTED_ID / EXPECTED_TS constants for the build flow to override
- One natural sub-module: sysid_rd_xact, a single Avalon read transaction (address hold, waitrequest, readdatavalid, timeout) returning data and a valid/abort flag. The top-level FSM sequences two of these.

Test Plan:
- USE_RDV=0, responder returns 0x0 @0 and 0x58BEBBBF @1, waitrequest=0; start → reads on two consecutive cycles, done 3 cycles after start, pass=1, id_value=0x0, ts_value=0x58BEBBBF.
- Responder returns 0x12345678 @1 → done, id_ok=1, ts_ok=0, pass=0, ts_value=0x12345678.
- waitrequest high 5 cycles on each read → avm_read/address stable throughout, pass=1, done at cycle 13 after start.
- USE_RDV=1, readdatavalid 2 cycles after acceptance; extra stray readdatavalid while IDLE → captures correct, stray ignored, pass=1.
- TIMEOUT_CYC=16, waitrequest stuck high → avm_read drops after 16 cycles, timeout=1, pass=0, done pulse once; second start with a healthy slave → pass=1, timeout cleared.
- Reset asserted during ID_WAIT, and start pulsed while busy → all outputs 0 during reset, no spurious done, busy-time start causes no restart.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID check master.
package sysid_pkg;

  // Top-level check sequencer states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ID_CMD  = 3'd1,
    S_ID_WAIT = 3'd2,
    S_TS_CMD  = 3'd3,
    S_TS_WAIT = 3'd4,
    S_FIN     = 3'd5
  } chk_state_e;

  // Phases of a single Avalon read transaction.
  typedef enum logic [1:0] {
    X_IDLE = 2'd0,
    X_CMD  = 2'd1,
    X_WAIT = 2'd2
  } xact_state_e;

  // Word addresses of the system-ID slave registers.
  localparam int unsigned ADDR_ID = 32'd0;
  localparam int unsigned ADDR_TS = 32'd1;

  // Build-flow defaults; the integration overrides these per image.
  localparam logic [31:0] DEF_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'h58BE_BBBF;

  // True when the cycle being spent now is the last one the budget allows.
  function automatic logic tmo_reached(input logic [7:0] cnt, input logic [7:0] lim);
    return (({1'b0, cnt} + 9'd1) >= {1'b0, lim});
  endfunction

endpackage

// File: rtl/sysid_check_master_rd_xact.sv
// One Avalon-MM read: holds read/address through waitrequest, optionally
// waits for readdatavalid, and aborts once the cycle budget is spent.
module sysid_rd_xact
  import sysid_pkg::*;
#(
  parameter int ADDR_W      = 1,
  parameter int USE_RDV     = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  output logic              avm_read_o,
  output logic [ADDR_W-1:0] avm_address_o,
  input  logic              avm_waitrequest_i,
  input  logic              avm_readdatavalid_i,
  output logic              accept_o,
  output logic              data_ok_o,
  output logic              abort_o
);

  localparam logic       RDV_MODE = (USE_RDV != 0);
  localparam logic [7:0] TMO_LIM  = 8'(TIMEOUT_CYC);

  xact_state_e       xs_q, xs_d;
  logic              read_q, read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cnt_inc_s;
  logic              tmo_s;
  logic              accept_s, data_ok_s, abort_s;

  // Transaction phase, strobe/address hold and budget counting.
  always_comb begin
    xs_d      = xs_q;
    read_d    = read_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    accept_s  = 1'b0;
    data_ok_s = 1'b0;
    abort_s   = 1'b0;
    tmo_s     = tmo_reached(cnt_q, TMO_LIM);
    cnt_inc_s = cnt_q + 8'd1;
    case (xs_q)
      X_IDLE: begin
        if (issue_i) begin
          xs_d   = X_CMD;
          read_d = 1'b1;
          addr_d = issue_addr_i;
          cnt_d  = 8'd0;
        end else begin
          read_d = 1'b0;
        end
      end
      X_CMD: begin
        if (!avm_waitrequest_i) begin
          accept_s = 1'b1;
          if (!RDV_MODE) begin
            // Data is valid on acceptance; a follow-on read may start at once.
            data_ok_s = 1'b1;
            if (issue_i) begin
              xs_d   = X_CMD;
              read_d = 1'b1;
              addr_d = issue_addr_i;
              cnt_d  = 8'd0;
            end else begin
              xs_d   = X_IDLE;
              read_d = 1'b0;
            end
          end else if (tmo_s) begin
            // Accepted on the last budget cycle, data can no longer arrive in time.
            abort_s = 1'b1;
            xs_d    = X_IDLE;
            read_d  = 1'b0;
          end else begin
            xs_d   = X_WAIT;
            read_d = 1'b0;
            cnt_d  = cnt_inc_s;
          end
        end else if (tmo_s) begin
          // Only case where read is dropped while the slave still stalls.
          abort_s = 1'b1;
          xs_d    = X_IDLE;
          read_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      X_WAIT: begin
        if (avm_readdatavalid_i) begin
          data_ok_s = 1'b1;
          if (issue_i) begin
            xs_d   = X_CMD;
            read_d = 1'b1;
            addr_d = issue_addr_i;
            cnt_d  = 8'd0;
          end else begin
            xs_d   = X_IDLE;
            read_d = 1'b0;
          end
        end else if (tmo_s) begin
          abort_s = 1'b1;
          xs_d    = X_IDLE;
          read_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        xs_d   = X_IDLE;
        read_d = 1'b0;
        cnt_d  = 8'd0;
      end
    endcase
  end

  // Transaction registers; reset drops the read strobe immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xs_q   <= X_IDLE;
      read_q <= 1'b0;
      addr_q <= '0;
      cnt_q  <= 8'd0;
    end else begin
      xs_q   <= xs_d;
      read_q <= read_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign avm_read_o    = read_q;
  assign avm_address_o = addr_q;
  assign accept_o      = accept_s;
  assign data_ok_o     = data_ok_s;
  assign abort_o       = abort_s;

endmodule

// File: rtl/sysid_check_master.sv
// System-ID check master: reads the ID and timestamp words from a sysid
// slave, compares them against the build constants and reports the verdict.
module sysid_check_master
  import sysid_pkg::*;
#(
  parameter int                ADDR_W      = 1,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] EXPECTED_ID = DATA_W'(DEF_EXPECTED_ID),
  parameter logic [DATA_W-1:0] EXPECTED_TS = DATA_W'(DEF_EXPECTED_TS),
  parameter int                USE_RDV     = 0,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value
);

  chk_state_e        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              id_ok_q, id_ok_d;
  logic              ts_ok_q, ts_ok_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] id_value_q, id_value_d;
  logic [DATA_W-1:0] ts_value_q, ts_value_d;

  logic              issue_s;
  logic [ADDR_W-1:0] issue_addr_s;
  logic              x_accept_s, x_ok_s, x_abort_s;
  logic              id_match_s, ts_match_s;

  sysid_rd_xact #(
    .ADDR_W      (ADDR_W),
    .USE_RDV     (USE_RDV),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_xact (
    .clk_i               (clock),
    .rst_i               (reset),
    .issue_i             (issue_s),
    .issue_addr_i        (issue_addr_s),
    .avm_read_o          (avm_read),
    .avm_address_o       (avm_address),
    .avm_waitrequest_i   (avm_waitrequest),
    .avm_readdatavalid_i (avm_readdatavalid),
    .accept_o            (x_accept_s),
    .data_ok_o           (x_ok_s),
    .abort_o             (x_abort_s)
  );

  // Sequencer: issue ID read, then timestamp read, then publish the verdict.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    id_ok_d      = id_ok_q;
    ts_ok_d      = ts_ok_q;
    timeout_d    = timeout_q;
    id_value_d   = id_value_q;
    ts_value_d   = ts_value_q;
    issue_s      = 1'b0;
    issue_addr_s = ADDR_W'(ADDR_ID);
    id_match_s   = (avm_readdata == EXPECTED_ID);
    ts_match_s   = (avm_readdata == EXPECTED_TS);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_ID_CMD;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          id_ok_d      = 1'b0;
          ts_ok_d      = 1'b0;
          timeout_d    = 1'b0;
          issue_s      = 1'b1;
          issue_addr_s = ADDR_W'(ADDR_ID);
        end else begin
          busy_d = 1'b0;
        end
      end
      S_ID_CMD, S_ID_WAIT: begin
        if (x_abort_s) begin
          state_d   = S_FIN;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else if (x_ok_s) begin
          id_value_d   = avm_readdata;
          id_ok_d      = id_match_s;
          state_d      = S_TS_CMD;
          issue_s      = 1'b1;
          issue_addr_s = ADDR_W'(ADDR_TS);
        end else if (x_accept_s) begin
          state_d = S_ID_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      S_TS_CMD, S_TS_WAIT: begin
        if (x_abort_s) begin
          state_d   = S_FIN;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else if (x_ok_s) begin
          ts_value_d = avm_readdata;
          ts_ok_d    = ts_match_s;
          pass_d     = id_ok_q & ts_match_s;
          state_d    = S_FIN;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else if (x_accept_s) begin
          state_d = S_TS_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      S_FIN: begin
        // A start coinciding with done is dropped here on purpose.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers, cleared immediately by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: two instances (latency-0 and readdatavalid
// slaves) driven by scripted responders, checked cycle by cycle against a
// timeline computed from the transaction rules.
module tb_sysid_check_master;

  localparam int          TO0    = 16;
  localparam int          TO1    = 20;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h58BE_BBBF;
  localparam int          TL     = 64;

  logic        clock;
  logic        reset;
  logic        start_s  [2];
  logic        wait_s   [2];
  logic [31:0] rdata_s  [2];
  logic        rdv_s    [2];
  logic        addr_s   [2];
  logic        read_s   [2];
  logic        busy_s   [2];
  logic        done_s   [2];
  logic        pass_s   [2];
  logic        idok_s   [2];
  logic        tsok_s   [2];
  logic        tmo_s    [2];
  logic [31:0] idv_s    [2];
  logic [31:0] tsv_s    [2];
  logic [31:0] prev_id  [2];
  logic [31:0] prev_ts  [2];

  int checks = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  sysid_check_master #(
    .ADDR_W(1), .DATA_W(32), .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .USE_RDV(0), .TIMEOUT_CYC(TO0)
  ) dut0 (
    .clock(clock), .reset(reset), .start(start_s[0]),
    .avm_address(addr_s[0]), .avm_read(read_s[0]),
    .avm_waitrequest(wait_s[0]), .avm_readdata(rdata_s[0]),
    .avm_readdatavalid(rdv_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .id_ok(idok_s[0]), .ts_ok(tsok_s[0]), .timeout(tmo_s[0]),
    .id_value(idv_s[0]), .ts_value(tsv_s[0])
  );

  sysid_check_master #(
    .ADDR_W(1), .DATA_W(32), .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .USE_RDV(1), .TIMEOUT_CYC(TO1)
  ) dut1 (
    .clock(clock), .reset(reset), .start(start_s[1]),
    .avm_address(addr_s[1]), .avm_read(read_s[1]),
    .avm_waitrequest(wait_s[1]), .avm_readdata(rdata_s[1]),
    .avm_readdatavalid(rdv_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .id_ok(idok_s[1]), .ts_ok(tsok_s[1]), .timeout(tmo_s[1]),
    .id_value(idv_s[1]), .ts_value(tsv_s[1])
  );

  task automatic chk_bit(input string name, input int sel, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %b expected %b at %0t", name, sel, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string name, input int sel, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, sel, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input int sel);
    chk_bit("rst_read", sel, read_s[sel], 1'b0);
    chk_bit("rst_addr", sel, addr_s[sel], 1'b0);
    chk_bit("rst_busy", sel, busy_s[sel], 1'b0);
    chk_bit("rst_done", sel, done_s[sel], 1'b0);
    chk_bit("rst_pass", sel, pass_s[sel], 1'b0);
    chk_bit("rst_idok", sel, idok_s[sel], 1'b0);
    chk_bit("rst_tsok", sel, tsok_s[sel], 1'b0);
    chk_bit("rst_tmo", sel, tmo_s[sel], 1'b0);
    chk_word("rst_idv", sel, idv_s[sel], 32'd0);
    chk_word("rst_tsv", sel, tsv_s[sel], 32'd0);
  endtask

  // One complete check on instance sel. The slave behaviour per read is given
  // as (stall cycles, readdatavalid delay after acceptance, data). Called at
  // posedge+1; returns at posedge+1 with the DUT idle again.
  task automatic run_check(input int sel,
                           input int w_id, input int d_id, input logic [31:0] v_id,
                           input int w_ts, input int d_ts, input logic [31:0] v_ts,
                           input bit busy_starts,
                           output int done_at, output int reads_seen);
    logic        e_read [TL];
    logic        e_addr [TL];
    logic        d_wait [TL];
    logic        d_rdv  [TL];
    logic [31:0] d_data [TL];
    int          wv [2];
    int          dv [2];
    logic [31:0] vv [2];
    int          to, s, len, lim, done_k;
    bit          rdv, alive, ok_id, ok_ts;
    logic [31:0] e_idv, e_tsv;
    logic        e_idok, e_tsok, e_pass, e_tmo;

    to = (sel == 0) ? TO0 : TO1;
    rdv = (sel == 1);
    wv[0] = w_id; dv[0] = d_id; vv[0] = v_id;
    wv[1] = w_ts; dv[1] = d_ts; vv[1] = v_ts;
    for (int k = 0; k < TL; k++) begin
      e_read[k] = 1'b0;
      e_addr[k] = 1'b0;
      d_wait[k] = 1'b0;
      d_rdv[k]  = rdv && ($urandom_range(0, 1) == 32'd1);
      d_data[k] = $urandom;
    end
    d_rdv[0] = rdv;

    // Each read lasts until its data cycle or until the budget is spent.
    s = 1; alive = 1'b1; ok_id = 1'b0; ok_ts = 1'b0;
    for (int t = 0; t < 2; t++) begin
      if (alive) begin
        len = rdv ? (wv[t] + 1 + dv[t]) : (wv[t] + 1);
        lim = (len <= to) ? len : to;
        for (int j = 0; j < lim; j++) begin
          e_read[s + j] = (j <= wv[t]);
          e_addr[s + j] = (t == 1);
          d_wait[s + j] = (j < wv[t]);
          if (rdv && j > wv[t]) d_rdv[s + j] = (j == len - 1);
          if (j == len - 1) d_data[s + j] = vv[t];
        end
        s = s + lim;
        if (len > to) alive = 1'b0;
        else if (t == 0) ok_id = 1'b1;
        else ok_ts = 1'b1;
      end
    end
    done_k = s;

    e_idv  = ok_id ? vv[0] : prev_id[sel];
    e_tsv  = ok_ts ? vv[1] : prev_ts[sel];
    e_idok = ok_id && (vv[0] == EXP_ID);
    e_tsok = ok_ts && (vv[1] == EXP_TS);
    e_tmo  = !ok_ts;
    e_pass = e_idok && e_tsok;

    done_at = -1;
    reads_seen = 0;
    start_s[sel] = 1'b1;
    wait_s[sel]  = d_wait[0];
    rdv_s[sel]   = d_rdv[0];
    rdata_s[sel] = d_data[0];
    for (int k = 1; k <= done_k + 2; k++) begin
      @(posedge clock);
      #1;
      if (k < done_k)       start_s[sel] = busy_starts && ($urandom_range(0, 2) == 32'd0);
      else if (k == done_k) start_s[sel] = busy_starts;
      else                  start_s[sel] = 1'b0;
      wait_s[sel]  = d_wait[k];
      rdv_s[sel]   = d_rdv[k];
      rdata_s[sel] = d_data[k];
      if (read_s[sel] === 1'b1) reads_seen++;
      if (done_s[sel] === 1'b1 && done_at < 0) done_at = k;
      chk_bit("read", sel, read_s[sel], e_read[k]);
      if (e_read[k]) chk_bit("addr", sel, addr_s[sel], e_addr[k]);
      chk_bit("done", sel, done_s[sel], k == done_k);
      chk_bit("busy", sel, busy_s[sel], k < done_k);
      if (k < done_k) begin
        chk_bit("pass_run", sel, pass_s[sel], 1'b0);
        chk_bit("tmo_run", sel, tmo_s[sel], 1'b0);
      end else begin
        chk_bit("pass", sel, pass_s[sel], e_pass);
        chk_bit("id_ok", sel, idok_s[sel], e_idok);
        chk_bit("ts_ok", sel, tsok_s[sel], e_tsok);
        chk_bit("timeout", sel, tmo_s[sel], e_tmo);
        chk_word("id_value", sel, idv_s[sel], e_idv);
        chk_word("ts_value", sel, tsv_s[sel], e_tsv);
      end
    end
    prev_id[sel] = e_idv;
    prev_ts[sel] = e_tsv;
    start_s[sel] = 1'b0;
    wait_s[sel]  = 1'b0;
    rdv_s[sel]   = 1'b0;
  endtask

  task automatic rand_run(input int sel);
    int w0, w1, d0, d1, da, rs;
    logic [31:0] v0, v1;
    w0 = $urandom_range(0, 4);
    w1 = $urandom_range(0, 4);
    if ($urandom_range(0, 5) == 32'd0) w0 = $urandom_range(10, 25);
    if ($urandom_range(0, 5) == 32'd0) w1 = $urandom_range(10, 25);
    d0 = $urandom_range(1, 3);
    d1 = $urandom_range(1, 3);
    v0 = ($urandom_range(0, 1) == 32'd1) ? EXP_ID : $urandom;
    v1 = ($urandom_range(0, 1) == 32'd1) ? EXP_TS : $urandom;
    run_check(sel, w0, d0, v0, w1, d1, v1, 1'b1, da, rs);
  endtask

  initial begin
    int da, rs;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; wait_s[i] = 1'b0; rdv_s[i] = 1'b0; rdata_s[i] = 32'd0;
      prev_id[i] = 32'd0; prev_ts[i] = 32'd0;
    end
    #1 reset = 1'b1;
    #1;
    chk_zero(0);
    chk_zero(1);
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock);
    #1;

    // Latency-0 slave, matching image: two back-to-back reads, done at +3.
    run_check(0, 0, 1, EXP_ID, 0, 1, EXP_TS, 1'b0, da, rs);
    chk_word("lat0_done_cycle", 0, 32'(da), 32'd3);
    chk_word("lat0_reads", 0, 32'(rs), 32'd2);

    // Timestamp mismatch.
    run_check(0, 0, 1, EXP_ID, 0, 1, 32'h1234_5678, 1'b0, da, rs);
    chk_word("ts_mis_value", 0, tsv_s[0], 32'h1234_5678);
    chk_bit("ts_mis_pass", 0, pass_s[0], 1'b0);

    // Five stall cycles on each read: done at +13.
    run_check(0, 5, 1, EXP_ID, 5, 1, EXP_TS, 1'b1, da, rs);
    chk_word("stall_done_cycle", 0, 32'(da), 32'd13);
    chk_bit("stall_pass", 0, pass_s[0], 1'b1);

    // Stuck waitrequest: read held 16 cycles, then abort.
    run_check(0, 40, 1, EXP_ID, 0, 1, EXP_TS, 1'b0, da, rs);
    chk_word("tmo_reads", 0, 32'(rs), 32'd16);
    chk_word("tmo_done_cycle", 0, 32'(da), 32'd17);
    chk_bit("tmo_flag", 0, tmo_s[0], 1'b1);

    // Healthy slave afterwards clears timeout.
    run_check(0, 1, 1, EXP_ID, 2, 1, EXP_TS, 1'b0, da, rs);
    chk_bit("recover_tmo", 0, tmo_s[0], 1'b0);
    chk_bit("recover_pass", 0, pass_s[0], 1'b1);

    for (int n = 0; n < 12; n++) rand_run(0);

    // Readdatavalid slave, data two cycles after acceptance, stray rdv in idle.
    run_check(1, 0, 2, EXP_ID, 0, 2, EXP_TS, 1'b0, da, rs);
    chk_word("rdv_done_cycle", 1, 32'(da), 32'd7);
    chk_bit("rdv_pass", 1, pass_s[1], 1'b1);

    for (int n = 0; n < 12; n++) rand_run(1);

    // Reset while dut1 waits for ID data; start pulsed during reset.
    start_s[1] = 1'b1;
    @(posedge clock); #1;
    start_s[1] = 1'b0;
    @(posedge clock); #1;
    chk_bit("pre_rst_busy", 1, busy_s[1], 1'b1);
    chk_bit("pre_rst_read", 1, read_s[1], 1'b0);
    #2 reset = 1'b1;
    start_s[1] = 1'b1;
    #1;
    chk_zero(0);
    chk_zero(1);
    @(posedge clock); #1;
    chk_zero(1);
    #2 reset = 1'b0;
    start_s[1] = 1'b0;
    rdv_s[1] = 1'b1;
    rdata_s[1] = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      chk_bit("post_rst_done", 1, done_s[1], 1'b0);
      chk_bit("post_rst_busy", 1, busy_s[1], 1'b0);
      chk_bit("post_rst_read", 1, read_s[1], 1'b0);
      chk_word("post_rst_idv", 1, idv_s[1], 32'd0);
    end
    rdv_s[1] = 1'b0;
    prev_id[0] = 32'd0; prev_ts[0] = 32'd0;
    prev_id[1] = 32'd0; prev_ts[1] = 32'd0;

    run_check(1, 1, 1, EXP_ID, 1, 3, EXP_TS, 1'b1, da, rs);
    run_check(0, 0, 1, 32'h0000_0001, 3, 1, EXP_TS, 1'b0, da, rs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
